// File: rtl/rv_pipe_pkg.sv
// Shared types and constants for the RV32I 5-stage pipeline.
// Holds the fetch FSM state encoding, the bubble encoding, the default
// reset PC and the IF/ID pipeline register layout.
package rv_pipe_pkg;

    typedef enum logic [1:0] {
        F_REQ  = 2'd0,   // drive a fetch request for PCF
        F_WAIT = 2'd1,   // one request outstanding, waiting for its response
        F_HOLD = 2'd2    // response buffered locally while decode is stalled
    } fetch_state_t;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    // Word-align an address by clearing its two low bits.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Turn an IF/ID entry into a bubble; PC fields keep their old values.
    function automatic if_id_t make_bubble(input if_id_t cur);
        if_id_t b;
        b       = cur;
        b.instr = NOP_INSTR;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_ctrl_fsm.sv
// Fetch control FSM: tracks the single outstanding imem request, the kill
// flag for responses made stale by a redirect, and the hold state used when
// a response lands while decode is stalled. Produces the request strobe and
// the per-cycle handshake qualifiers consumed by the fetch datapath.
module fetch_ctrl_fsm
    import rv_pipe_pkg::*;
(
    input  logic clk,
    input  logic rst,          // synchronous, active-high
    input  logic stall,        // decode stall
    input  logic redirect,     // E-stage redirect
    input  logic req_ready,    // imem accepts the request this cycle
    input  logic rsp_valid,    // imem response valid this cycle
    output logic req_valid,    // fetch request strobe
    output logic instr_avail,  // an instruction is available this cycle
    output logic hold_valid,   // the available instruction comes from the hold buffer
    output logic consume,      // instruction moves into IF/ID and PCF advances
    output logic capture,      // response goes into the hold buffer
    output logic b2b           // back-to-back request for PCF+4 in this cycle
);

    fetch_state_t state, state_next;
    logic         kill, kill_next;
    logic         in_wait;
    logic         rsp_good;

    assign in_wait     = (state == F_WAIT);
    assign hold_valid  = (state == F_HOLD);
    // A response that arrives with kill set belongs to the abandoned path.
    assign rsp_good    = in_wait && rsp_valid && !kill;
    assign instr_avail = rsp_good || hold_valid;
    assign consume     = instr_avail && !stall && !redirect;
    assign capture     = rsp_good && stall && !redirect;
    assign b2b         = in_wait && consume;
    // A redirect withdraws any request: the address it would carry is stale.
    assign req_valid   = !rst && !redirect && ((state == F_REQ) || b2b);

    // Next-state and kill-flag decode.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_next = state;
        kill_next  = kill;
        if (redirect) begin
            if (in_wait && !rsp_valid) begin
                // Request still in flight: mark its response for discard.
                kill_next = 1'b1;
            end else begin
                kill_next  = 1'b0;
                state_next = F_REQ;
            end
        end else begin
            case (state)
                F_REQ: begin
                    if (req_ready) state_next = F_WAIT;
                end
                F_WAIT: begin
                    if (rsp_valid) begin
                        if (kill) begin
                            kill_next  = 1'b0;
                            state_next = F_REQ;
                        end else if (stall) begin
                            state_next = F_HOLD;
                        end else if (req_ready) begin
                            state_next = F_WAIT;   // back-to-back request accepted
                        end else begin
                            state_next = F_REQ;    // retry PCF+4 next cycle
                        end
                    end
                end
                F_HOLD: begin
                    if (!stall) state_next = F_REQ;
                end
                default: begin
                    state_next = F_REQ;
                    kill_next  = 1'b0;
                end
            endcase
        end
    end

    // State and kill registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= F_REQ;
            kill  <= 1'b0;
        end else begin
            state <= state_next;
            kill  <= kill_next;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage RV32I pipeline: owns PCF, the imem request/response
// handshake (at most one request outstanding), the stall hold buffer and the
// IF/ID pipeline register feeding decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN adds MisalignD and reports a
// misaligned redirect target as a marked bubble instead of silently aligning.
module fetch_stage
    import rv_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        CLK,
    input  logic        Rst,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        ImemReqValid,
    input  logic        ImemReqReady,
    output logic [31:0] ImemAddr,
    input  logic        ImemRspValid,
    input  logic [31:0] ImemRspData,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        MisalignD
`endif
);

    logic [31:0] pcf;
    logic [31:0] pcf_plus4;
    logic [31:0] redirect_pc;
    logic [31:0] hold_data;
    logic [31:0] fetched_instr;
    if_id_t      if_id, if_id_next;

    logic instr_avail;
    logic hold_valid;
    logic consume;
    logic capture;
    logic b2b;

    // Wraps modulo 2^32 by construction.
    assign pcf_plus4   = pcf + 32'd4;
    assign redirect_pc = align_pc(PCTargetE);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic target_misaligned;
    logic misalign_q, misalign_next;
    assign target_misaligned = |PCTargetE[1:0];
    assign MisalignD         = misalign_q;
`else
    // Low target bits are dropped when the trap feature is absent.
    logic unused_target_lsbs;
    assign unused_target_lsbs = |PCTargetE[1:0];
`endif

    fetch_ctrl_fsm u_ctrl (
        .clk         (CLK),
        .rst         (Rst),
        .stall       (StallD),
        .redirect    (PCSrcE),
        .req_ready   (ImemReqReady),
        .rsp_valid   (ImemRspValid),
        .req_valid   (ImemReqValid),
        .instr_avail (instr_avail),
        .hold_valid  (hold_valid),
        .consume     (consume),
        .capture     (capture),
        .b2b         (b2b)
    );

    // The back-to-back request targets the instruction after the one being
    // consumed this cycle; otherwise the request address is PCF itself.
    assign ImemAddr      = b2b ? pcf_plus4 : pcf;
    assign fetched_instr = hold_valid ? hold_data : ImemRspData;

    // Program counter: reset, redirect, or advance on consume.
    always_ff @(posedge CLK) begin
        if (Rst) begin
            pcf <= align_pc(RESET_PC);
        end else if (PCSrcE) begin
            pcf <= redirect_pc;
        end else if (consume) begin
            pcf <= pcf_plus4;
        end
    end

    // Hold buffer: captures a response that arrives while decode is stalled.
    always_ff @(posedge CLK) begin
        // NOTE: this data buffer has no reset; its contents are only used
        // while the FSM's hold state says they are valid.
        if (capture) begin
            hold_data <= ImemRspData;
        end
    end

    // IF/ID next value; priority is redirect, flush, then stall.
    always_comb begin
        if_id_next = if_id;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_next = misalign_q;
`endif
        if (PCSrcE) begin
            if_id_next = make_bubble(if_id);
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_next = target_misaligned;
            if (target_misaligned) begin
                if_id_next.pc       = PCTargetE;
                if_id_next.pc_plus4 = PCTargetE + 32'd4;
            end
`endif
        end else if (FlushD) begin
            if_id_next = make_bubble(if_id);
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_next = 1'b0;
`endif
        end else if (!StallD) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_next = 1'b0;
`endif
            if (instr_avail) begin
                if_id_next.instr    = fetched_instr;
                if_id_next.pc       = pcf;
                if_id_next.pc_plus4 = pcf_plus4;
                if_id_next.valid    = 1'b1;
            end else begin
                if_id_next = make_bubble(if_id);
            end
        end
    end

    // IF/ID register with synchronous reset to a bubble at PC 0.
    always_ff @(posedge CLK) begin
        if (Rst) begin
            if_id.instr    <= NOP_INSTR;
            if_id.pc       <= 32'h0;
            if_id.pc_plus4 <= 32'h0;
            if_id.valid    <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q     <= 1'b0;
`endif
        end else begin
            if_id          <= if_id_next;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q     <= misalign_next;
`endif
        end
    end

    assign InstrD   = if_id.instr;
    assign PCD      = if_id.pc;
    assign PCPlus4D = if_id.pc_plus4;
    assign ValidD   = if_id.valid;

endmodule
